// File: rtl/riscv_pkg.sv
// Shared RV32I definitions used by the fetch unit and the control unit:
// default widths, opcode constants, the fetch buffer entry and the fetch FSM states.
package riscv_pkg;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bundles the instruction-memory request/response channel and the decode-side
// handshake of the fetch unit; master = fetch unit, slave = memory + decode.
interface instruction_fetch_unit_if #(
    parameter int XLEN = 32
);
    // Valid/ready: a transfer happens on a rising edge where valid and ready are both 1;
    // valid does not wait on ready. imem responses have no ready and are never stalled.
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_resp_valid;
    logic [XLEN-1:0] imem_resp_data;
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_instr;
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] if_pc_plus4;

    modport master (
        output imem_req_valid, imem_addr, if_valid, if_instr, if_pc, if_pc_plus4,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, if_ready
    );

    modport slave (
        input  imem_req_valid, imem_addr, if_valid, if_instr, if_pc, if_pc_plus4,
        output imem_req_ready, imem_resp_valid, imem_resp_data, if_ready
    );

endinterface

// File: rtl/instruction_fetch_unit_fifo.sv
// Synchronous instruction buffer of fetch_entry_t with push/pop/flush and an
// occupancy count; the head entry is presented combinationally.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_pop;

    assign do_pop = pop && (count != '0);
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: owns the PC, issues word fetches, buffers responses and hands
// them to decode; redirects squash in-flight fetches. FETCH_MISALIGN_TRAP_EN adds fetch_misaligned.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = riscv_pkg::RESET_PC,
    parameter int          XLEN       = riscv_pkg::XLEN,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pc_select,
    input  logic [XLEN-1:0]           branch_target,
    instruction_fetch_unit_if.master  bus,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic                      fetch_misaligned,
`endif
    output riscv_pkg::fetch_state_t   fsm_state
);

    import riscv_pkg::*;

    localparam int             CW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0]    CAP = FIFO_DEPTH[CW:0];

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [XLEN-1:0] target;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   outstanding_next;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   discard_next;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     occupancy;
    logic            accept;
    logic            push;
    logic            pop;
    fetch_entry_t    head;
    fetch_entry_t    push_entry;

    assign target    = {branch_target[XLEN-1:2], 2'b00};
    assign occupancy = {1'b0, fifo_count} + {1'b0, outstanding};
    assign fsm_state = state;

    // Buffered plus in-flight never exceeds the buffer size, so every response has a slot.
    assign bus.imem_req_valid = !reset && (state == RUN) && !pc_select && (occupancy < CAP);
    assign bus.imem_addr      = fetch_pc;
    assign accept             = bus.imem_req_valid && bus.imem_req_ready;

    assign bus.if_valid    = !reset && !pc_select && (fifo_count != '0);
    assign pop             = bus.if_valid && bus.if_ready;
    assign bus.if_instr    = bus.if_valid ? head.instr : '0;
    assign bus.if_pc       = bus.if_valid ? head.pc : '0;
    assign bus.if_pc_plus4 = bus.if_valid ? head.pc + XLEN'(4) : '0;

    assign push       = !reset && bus.imem_resp_valid && !pc_select && (discard == '0);
    assign push_entry = '{instr: bus.imem_resp_data, pc: resp_pc};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (pc_select),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

    always_comb begin
        state_next       = state;
        discard_next     = discard;
        outstanding_next = outstanding + CW'(accept) - CW'(bus.imem_resp_valid);
        if (pc_select) begin
            // Everything still in flight after this cycle belongs to the old stream.
            discard_next = outstanding_next;
            state_next   = (outstanding_next != '0) ? DRAIN : RUN;
        end else if (bus.imem_resp_valid && (discard != '0)) begin
            discard_next = discard - CW'(1);
            if (discard == CW'(1)) begin
                state_next = RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            state       <= state_next;
            outstanding <= outstanding_next;
            discard     <= discard_next;
            if (pc_select) begin
                fetch_pc <= target;
                resp_pc  <= target;
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + XLEN'(4);
                end
                if (push) begin
                    resp_pc <= resp_pc + XLEN'(4);
                end
            end
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_misaligned <= 1'b0;
        end else begin
            fetch_misaligned <= pc_select && (branch_target[1:0] != 2'b00);
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: in-order latency memory model, stream-level
// reference model of what must reach decode, directed phases then random traffic.
`timescale 1ns/1ps
module tb_instruction_fetch_unit;
    import riscv_pkg::*;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         pc_select = 1'b0;
    logic [31:0]  branch_target = 32'h0;
    fetch_state_t fsm_state;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic         fetch_misaligned;
`endif

    instruction_fetch_unit_if #(.XLEN(32)) bus ();

    instruction_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .XLEN       (32),
        .FIFO_DEPTH (2)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .pc_select        (pc_select),
        .branch_target    (branch_target),
        .bus              (bus),
`ifdef FETCH_MISALIGN_TRAP_EN
        .fetch_misaligned (fetch_misaligned),
`endif
        .fsm_state        (fsm_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } req_t;

    req_t        memq[$];
    logic [31:0] exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          buffered = 0;
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] exp_fetch_pc = 32'h0;
    bit          exp_mis = 1'b0;

    int          ready_pct = 100;
    int          ifready_pct = 100;
    int          lat_min = 0;
    int          lat_max = 0;
    int          sel_pct = 0;
    bit          force_sel = 1'b0;
    logic [31:0] force_target = 32'h0;
    bit          collide_arm = 1'b0;
    bit          collide_fired = 1'b0;
    bit          capture_pending = 1'b0;
    bit          capture_req_pending = 1'b0;
    logic [31:0] captured_pc = 32'hDEAD_BEEF;
    logic [31:0] captured_req = 32'hDEAD_BEEF;
    int          max_occ = 0;
    int          first_valid_cyc = -1;
    int          stray_2xx = 0;
    int          mis_cnt = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return {~addr[15:0], addr[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic int stale_cnt();
        int n = 0;
        foreach (memq[i]) if (memq[i].stale) n++;
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1;
        pc_select = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.if_ready = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
            check("rst_req_valid", bus.imem_req_valid, 0);
            check("rst_if_valid", bus.if_valid, 0);
            check("rst_if_instr", bus.if_instr, 0);
            check("rst_if_pc", bus.if_pc, 0);
            check("rst_if_pc_plus4", bus.if_pc_plus4, 0);
            check("rst_state", fsm_state, RUN);
`ifdef FETCH_MISALIGN_TRAP_EN
            check("rst_misaligned", fetch_misaligned, 0);
`endif
        end
        memq.delete();
        exp_q.delete();
        buffered = 0;
        exp_pc = 32'h0;
        exp_fetch_pc = 32'h0;
        exp_mis = 1'b0;
        cyc = 0;
        first_valid_cyc = -1;
        capture_pending = 1'b0;
        capture_req_pending = 1'b0;
    endtask

    task automatic step();
        bit          sel;
        bit          exp_valid;
        bit          exp_req;
        logic [31:0] tgt;
        req_t        r;
        @(negedge clk);
        reset = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data = $urandom();
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data = mem_word(memq[0].addr);
        end
        bus.imem_req_ready = ($urandom_range(1, 100) <= ready_pct);
        bus.if_ready = ($urandom_range(1, 100) <= ifready_pct);
        sel = 1'b0;
        tgt = $urandom();
        if (force_sel) begin
            sel = 1'b1;
            tgt = force_target;
            force_sel = 1'b0;
        end else if (collide_arm && bus.imem_resp_valid && buffered > 0 && bus.if_ready) begin
            sel = 1'b1;
            tgt = 32'h180;
            collide_arm = 1'b0;
            collide_fired = 1'b1;
        end else if ($urandom_range(1, 100) <= sel_pct) begin
            sel = 1'b1;
            tgt = $urandom_range(0, 32'hFFFF);
        end
        pc_select = sel;
        branch_target = tgt;
        #1;
        exp_valid = !sel && buffered > 0;
        exp_req = !sel && stale_cnt() == 0 && (memq.size() + buffered) < 2;
        check("if_valid", bus.if_valid, exp_valid);
        check("imem_req_valid", bus.imem_req_valid, exp_req);
        if (exp_valid && bus.if_valid) begin
            check("if_pc", bus.if_pc, exp_pc);
            check("if_instr", bus.if_instr, mem_word(exp_pc));
            check("if_pc_plus4", bus.if_pc_plus4, exp_pc + 32'd4);
        end
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            check("imem_addr", bus.imem_addr, exp_fetch_pc);
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        check("fetch_misaligned", fetch_misaligned, exp_mis);
        if (fetch_misaligned) mis_cnt++;
`endif
        if (first_valid_cyc < 0 && bus.if_valid) first_valid_cyc = cyc;

        if (bus.imem_resp_valid) begin
            r = memq.pop_front();
            if (!r.stale && !sel) begin
                buffered++;
                exp_q.push_back(r.addr);
            end
        end
        if (exp_valid && bus.if_ready) begin
            if (capture_pending) begin
                captured_pc = bus.if_pc;
                capture_pending = 1'b0;
            end
            if (bus.if_pc >= 32'h200 && bus.if_pc < 32'h300) stray_2xx++;
            void'(exp_q.pop_front());
            buffered--;
            exp_pc = exp_pc + 32'd4;
        end
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            if (capture_req_pending) begin
                captured_req = bus.imem_addr;
                capture_req_pending = 1'b0;
            end
            memq.push_back('{addr: bus.imem_addr, due: cyc + 1 + $urandom_range(lat_min, lat_max), stale: 1'b0});
            exp_fetch_pc = exp_fetch_pc + 32'd4;
        end
        exp_mis = sel && (tgt[1:0] != 2'b00);
        if (sel) begin
            foreach (memq[i]) memq[i].stale = 1'b1;
            buffered = 0;
            exp_q.delete();
            exp_pc = {tgt[31:2], 2'b00};
            exp_fetch_pc = {tgt[31:2], 2'b00};
            capture_pending = 1'b1;
            capture_req_pending = 1'b1;
        end
        if (memq.size() + buffered > max_occ) max_occ = memq.size() + buffered;
        cyc++;
    endtask

    logic [31:0] dec_log[$];
    always @(posedge clk) begin
        if (!reset && bus.if_valid && bus.if_ready) dec_log.push_back(bus.if_pc);
    end

    initial begin
        int base;
        bus.imem_req_ready = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data = 32'h0;
        bus.if_ready = 1'b0;

        do_reset(3);
        dec_log.delete();

        // Clean 1-cycle memory, decode always ready.
        repeat (20) step();
        check("first_if_valid_cycle", first_valid_cyc, 2);
        if (dec_log.size() < 3) begin
            check("early_decode_count", dec_log.size(), 3);
        end else begin
            check("dec_pc0", dec_log[0], 32'h0);
            check("dec_pc1", dec_log[1], 32'h4);
            check("dec_pc2", dec_log[2], 32'h8);
        end

        // Decode stall for 10 cycles, then release.
        ifready_pct = 0;
        max_occ = 0;
        repeat (10) step();
        check("stall_occupancy_cap", max_occ, 2);
        ifready_pct = 100;
        repeat (10) step();
        if (dec_log.size() > 0) begin
            check("no_loss_in_order", dec_log[dec_log.size() - 1] - dec_log[0], 32'(4 * (dec_log.size() - 1)));
        end else begin
            check("decode_progress", dec_log.size(), 1);
        end

        // Redirect with two fetches in flight.
        lat_min = 5;
        lat_max = 5;
        for (int k = 0; k < 20 && memq.size() != 2; k++) step();
        check("two_inflight_reached", memq.size(), 2);
        force_sel = 1'b1;
        force_target = 32'h100;
        step();
        lat_min = 0;
        lat_max = 0;
        repeat (20) step();
        check("redirect_first_pc", captured_pc, 32'h100);

        // Redirect colliding with a response and a pop.
        collide_fired = 1'b0;
        collide_arm = 1'b1;
        for (int k = 0; k < 30 && !collide_fired; k++) step();
        collide_arm = 1'b0;
        check("collide_fired", collide_fired, 1);
        repeat (10) step();
        check("collide_first_pc", captured_pc, 32'h180);

        // Back-to-back redirects while draining.
        stray_2xx = 0;
        lat_min = 5;
        lat_max = 5;
        for (int k = 0; k < 20 && memq.size() != 2; k++) step();
        check("two_inflight_reached_2", memq.size(), 2);
        force_sel = 1'b1;
        force_target = 32'h200;
        step();
        @(posedge clk);
        #1;
        check("drain_state", fsm_state, DRAIN);
        force_sel = 1'b1;
        force_target = 32'h300;
        step();
        lat_min = 0;
        lat_max = 0;
        repeat (30) step();
        check("drain_first_pc", captured_pc, 32'h300);
        check("drain_no_0x2xx", stray_2xx, 0);

        // Misaligned target.
        mis_cnt = 0;
        force_sel = 1'b1;
        force_target = 32'h102;
        step();
        repeat (6) step();
        check("misalign_fetch_addr", captured_req, 32'h100);
        check("misalign_first_pc", captured_pc, 32'h100);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("misalign_pulses", mis_cnt, 1);
`endif

        // Reset in the middle of traffic.
        ready_pct = 70;
        ifready_pct = 70;
        lat_max = 2;
        repeat (30) step();
        do_reset(2);
        ready_pct = 100;
        ifready_pct = 100;
        lat_max = 0;
        repeat (10) step();
        check("post_reset_first_valid", first_valid_cyc, 2);

        // Random traffic with random redirects.
        ready_pct = 70;
        ifready_pct = 70;
        lat_min = 0;
        lat_max = 3;
        sel_pct = 4;
        base = vectors;
        repeat (3000) step();
        check("random_phase_ran", (vectors - base) > 6000, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Front end of the pipelined RV32I core: owns the PC, issues word requests to instruction memory, buffers returned instructions, and hands them to decode/control with a valid/ready handshake.
- Consumes pc_select/branch_target from the execute stage, which is driven by the control unit's pc_select output, and performs redirect plus squash of stale in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- XLEN, 32, address/instruction width.
- FIFO_DEPTH, 2, instruction buffer entries; also the cap on buffered plus in-flight fetches (power of 2, ≥2).

Ports:
- clk  in  1  single rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- pc_select  in  1  redirect request from execute (taken branch/jump).
- branch_target  in  XLEN  redirect address, sampled when pc_select=1.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  XLEN  word-aligned fetch address.
- imem_resp_valid  in  1  response valid. Responses arrive in order, ≥1 cycle after acceptance, and cannot be back-pressured.
- imem_resp_data  in  XLEN  fetched instruction.
- if_valid  out  1  instruction available to decode.
- if_ready  in  1  decode accepts instruction (deasserted for stall).
- if_instr  out  XLEN  instruction to decode.
- if_pc  out  XLEN  PC of if_instr.
- if_pc_plus4  out  XLEN  if_pc + 4 (for JAL/JALR link).

Behaviour:
- Reset (synchronous, active-high): fetch_pc=RESET_PC, FIFO empty, outstanding=0, discard=0, state=RUN. Outputs: imem_req_valid=0, if_valid=0, if_instr/if_pc/if_pc_plus4=0. First request is issued in the cycle after reset deasserts.
- Issue rule (RUN): imem_req_valid=1 when fifo_count+outstanding < FIFO_DEPTH.
  - imem_addr=fetch_pc.
  - On valid&&ready: fetch_pc+=4 (wraps modulo 2^XLEN) and outstanding++.
- Response handling: on imem_resp_valid, outstanding--.
  - If discard>0: discard-- and the data is dropped.
  - Otherwise push {data, pc} into the FIFO. The FIFO can never overflow because of the issue rule.
  - The per-entry pc is taken from a response-PC counter that advances by 4 per accepted response.
- Output: if_valid = FIFO non-empty. if_instr/if_pc/if_pc_plus4 come from the head entry combinationally. Pop on if_valid&&if_ready.
- Redirect (pc_select=1, highest priority):
  - fetch_pc and response-PC both load {branch_target[XLEN-1:2],2'b00}.
  - FIFO is flushed the same cycle.
  - discard = outstanding after this cycle's accept/return; a response arriving in the redirect cycle is dropped.
  - imem_req_valid=0 during the redirect cycle.
  - if_valid is forced 0 in the redirect cycle; a pop in that cycle is ignored.
  - state→DRAIN if the new discard>0, else RUN.
- DRAIN: no issue. Each response decrements discard; at discard==0 go to RUN. A further pc_select in DRAIN reloads the PC and adds the new outstanding to discard.
- Simultaneous push and pop: both occur and the count is unchanged. Push into an empty FIFO appears on the outputs the next cycle (1-cycle response-to-decode latency).
- Reset mid-operation clears everything. Responses to requests accepted before reset are not squashed; the memory is reset on the same reset.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined: adds output fetch_misaligned (1 bit, reset 0). It is registered to 1 for one cycle when pc_select=1 and branch_target[1:0]!=0. The PC is still loaded with the aligned address.
- Undefined: no port; low bits are silently cleared.

Decomposition:
- Shared package riscv_pkg:
  - XLEN and RESET_PC defaults.
  - Opcode constants (OP_LUI … OP_ECALL) shared with the control unit.
  - NOP_INSTR = 32'h0000_0013.
  - fetch_entry_t struct {instr, pc}.
  - fetch_state_t enum {RUN, DRAIN}.
- Sub-module fetch_fifo: parameterised-depth synchronous FIFO of fetch_entry_t with push/pop/flush/count.

Test Plan:
- Reset release, memory 1-cycle latency, if_ready=1 → addresses 0x0,0x4,0x8…; if_pc matches; if_pc_plus4=if_pc+4; if_valid first asserts ≥2 cycles after reset.
- if_ready=0 for 10 cycles → at most 2 requests outstanding/buffered, no request while full; on release, instructions emerge in order with none lost.
- 2 fetches in flight, pc_select=1 with branch_target=0x100 → both late responses dropped; next if_pc=0x100.
- pc_select asserted in the same cycle as a response and a pop → response dropped, FIFO empty next cycle, then a fetch from the target.
- Repeated redirects during DRAIN (0x200, then 0x300) → only 0x300-stream instructions reach decode.
- FETCH_MISALIGN_TRAP_EN defined, branch_target=0x102 → fetch_misaligned pulses for 1 cycle, fetch from 0x100; undefined → fetch 0x100, no pulse.
